// File: rtl/cache_way_victim_select.sv
// Tree pseudo-LRU victim selection for a 4-way set-associative cache, with a
// request/acknowledge victim handshake and one-hot way write-enable decode.
module cache_way_victim_select #(
    parameter int unsigned SET_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SET_BITS-1:0] set_idx,
    input  logic                touch_valid,
    input  logic [1:0]          touch_way,
    input  logic                victim_req,
    input  logic                victim_ack,
    output logic                victim_valid,
    output logic [1:0]          victim_way,
    output logic [3:0]          victim_onehot,
    input  logic                wr_en,
    input  logic [1:0]          wr_way,
    output logic [3:0]          way_we
);

    localparam int unsigned NUM_SETS = 2 ** SET_BITS;

    typedef enum logic [0:0] {
        st_idle  = 1'b0,
        st_valid = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          way_q, way_d;
    logic [SET_BITS-1:0] set_q, set_d;
    logic [2:0]          plru_q [NUM_SETS];
    logic [2:0]          plru_d [NUM_SETS];
    logic                ack_fire;

    // Bit 0 picks the pair, bits 1/2 pick within the left/right pair.
    function automatic logic [1:0] plru_victim(input logic [2:0] b);
        return b[0] ? {1'b1, b[2]} : {1'b0, b[1]};
    endfunction

    // Point the tree away from way w so it becomes most recently used.
    function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
        logic [2:0] r;
        r    = b;
        r[0] = ~w[1];
        if (!w[1]) begin
            r[1] = ~w[0];
        end else begin
            r[2] = ~w[0];
        end
        return r;
    endfunction

    assign ack_fire = (state_q == st_valid) && victim_ack;

    // A same-set touch is applied first; the fill from an ack lands on top of it.
    always_comb begin
        for (int s = 0; s < NUM_SETS; s++) begin
            plru_d[s] = plru_q[s];
            if (touch_valid && (set_idx == SET_BITS'(s))) begin
                plru_d[s] = plru_touch(plru_d[s], touch_way);
            end
            if (ack_fire && (set_q == SET_BITS'(s))) begin
                plru_d[s] = plru_touch(plru_d[s], way_q);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        way_d   = way_q;
        set_d   = set_q;
        unique case (state_q)
            st_idle: begin
                if (victim_req) begin
                    set_d   = set_idx;
                    way_d   = plru_victim(plru_q[set_idx]);
                    state_d = st_valid;
                end
            end
            st_valid: begin
                if (victim_ack) begin
                    state_d = st_idle;
                end
            end
            default: state_d = st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= st_idle;
            way_q   <= 2'd0;
            set_q   <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                plru_q[s] <= 3'b000;
            end
        end else begin
            state_q <= state_d;
            way_q   <= way_d;
            set_q   <= set_d;
            for (int s = 0; s < NUM_SETS; s++) begin
                plru_q[s] <= plru_d[s];
            end
        end
    end

    assign victim_valid  = (state_q == st_valid);
    assign victim_way    = way_q;
    assign victim_onehot = victim_valid ? (4'b0001 << way_q) : 4'b0000;
    assign way_we        = wr_en ? (4'b0001 << wr_way) : 4'b0000;

endmodule
